// File: rtl/test_status_mmio.sv
`default_nettype none
// ============================================================================
// Module   : test_status_mmio
// Brief    : Memory-mapped test-status block: result/test-number registers,
//            pass/fail/timeout state, watchdog, registered readback.
//            Optional cycle counter enabled by TEST_STATUS_CYCLE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module test_status_mmio #(
    parameter logic [31:0] RESULT_ADDR    = 32'h3FFC,
    parameter logic [31:0] TESTNUM_ADDR   = 32'h3FF8,
    parameter logic [31:0] STATUS_ADDR    = 32'h3FF0,
    parameter logic [31:0] CYCLE_ADDR     = 32'h3FF4,
    parameter logic [31:0] PASS_CODE      = 32'hAA55AA55,
    parameter logic [31:0] FAIL_CODE      = 32'hFFFFFFFF,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DataADDR,
    input  logic [31:0] WriteData,
    input  logic [3:0]  mem_write_req,
    input  logic        mem_read_req,
    output logic [31:0] ReadData,
    output logic        test_done,
    output logic        test_pass,
    output logic        test_fail,
    output logic        test_timeout,
    output logic [31:0] result_q,
    output logic [31:0] test_num_q
);

    localparam logic [1:0]  S_RUN       = 2'd0;
    localparam logic [1:0]  S_PASS      = 2'd1;
    localparam logic [1:0]  S_FAIL      = 2'd2;
    localparam logic [1:0]  S_TIMEOUT   = 2'd3;
    localparam logic [31:0] C_WDOG_LAST = TIMEOUT_CYCLES - 32'd1;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_wdog;
    logic [31:0] r_result;
    logic [31:0] r_test_num;
    logic [31:0] w_test_num_nxt;
    logic [31:0] r_read_data;
    logic [31:0] w_read_mux;
    logic [31:0] w_cycle_val;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;

    logic        w_sel_result;
    logic        w_sel_testnum;
    logic        w_sel_status;
    logic        w_sel_cycle;
    logic        w_result_wr;
    logic        w_wdog_expire;
    logic        w_unused;

    // Word-granular decode; the byte offset within the word is irrelevant.
    assign w_sel_result  = (DataADDR[31:2] == RESULT_ADDR[31:2]);
    assign w_sel_testnum = (DataADDR[31:2] == TESTNUM_ADDR[31:2]);
    assign w_sel_status  = (DataADDR[31:2] == STATUS_ADDR[31:2]);
    assign w_sel_cycle   = (DataADDR[31:2] == CYCLE_ADDR[31:2]);
    assign w_unused      = ^DataADDR[1:0];

    // Only a full-word store while still running may touch the result.
    assign w_result_wr   = w_sel_result && (mem_write_req == 4'b1111) && (r_state == S_RUN);
    assign w_wdog_expire = (TIMEOUT_CYCLES != 32'd0) && (r_wdog == C_WDOG_LAST);

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_RUN) begin
            if (w_result_wr && (WriteData == PASS_CODE)) begin
                w_state_nxt = S_PASS;
            end else if (w_result_wr && (WriteData == FAIL_CODE)) begin
                w_state_nxt = S_FAIL;
            end else if (w_wdog_expire) begin
                w_state_nxt = S_TIMEOUT;
            end
        end
    end

    always_comb begin
        w_test_num_nxt = r_test_num;
        if (w_sel_testnum) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_write_req[i]) begin
                    w_test_num_nxt[8*i +: 8] = WriteData[8*i +: 8];
                end
            end
        end
    end

`ifdef TEST_STATUS_CYCLE_CNT_EN
    logic [31:0] r_cycle;

    // Counts cycles spent running; freezes once a verdict is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= 32'd0;
        end else if (r_state == S_RUN) begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_cycle_val = r_cycle;
`else
    assign w_cycle_val = 32'd0;
`endif

    always_comb begin
        w_read_mux = 32'd0;
        if (w_sel_result) begin
            w_read_mux = r_result;
        end else if (w_sel_testnum) begin
            w_read_mux = r_test_num;
        end else if (w_sel_status) begin
            w_read_mux = {28'd0, r_timeout, r_fail, r_pass, r_done};
        end else if (w_sel_cycle) begin
            w_read_mux = w_cycle_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_wdog      <= 32'd0;
            r_result    <= 32'd0;
            r_test_num  <= 32'd0;
            r_read_data <= 32'd0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_test_num <= w_test_num_nxt;
            if (r_state == S_RUN) begin
                r_wdog <= r_wdog + 32'd1;
            end
            if (w_result_wr) begin
                r_result <= WriteData;
            end
            if (mem_read_req) begin
                r_read_data <= w_read_mux;
            end
            // Flags track the state register exactly, one edge after the cause.
            r_done    <= (w_state_nxt != S_RUN);
            r_pass    <= (w_state_nxt == S_PASS);
            r_fail    <= (w_state_nxt == S_FAIL);
            r_timeout <= (w_state_nxt == S_TIMEOUT);
        end
    end

    assign ReadData     = r_read_data;
    assign test_done    = r_done;
    assign test_pass    = r_pass;
    assign test_fail    = r_fail;
    assign test_timeout = r_timeout;
    assign result_q     = r_result;
    assign test_num_q   = r_test_num;

endmodule
`default_nettype wire

// File: tb/tb_test_status_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_status_mmio
// Brief    : Directed + randomized self-checking bench for test_status_mmio.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_status_mmio;

    localparam logic [31:0] TO    = 32'd20;
    localparam logic [31:0] PASSC = 32'hAA55AA55;
    localparam logic [31:0] FAILC = 32'hFFFFFFFF;
    localparam int M_RUN = 0, M_PASS = 1, M_FAIL = 2, M_TIMEOUT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] DataADDR = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [3:0]  mem_write_req = 4'd0;
    logic        mem_read_req = 1'b0;
    logic [31:0] ReadData;
    logic        test_done, test_pass, test_fail, test_timeout;
    logic [31:0] result_q, test_num_q;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    test_status_mmio #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .DataADDR     (DataADDR),
        .WriteData    (WriteData),
        .mem_write_req(mem_write_req),
        .mem_read_req (mem_read_req),
        .ReadData     (ReadData),
        .test_done    (test_done),
        .test_pass    (test_pass),
        .test_fail    (test_fail),
        .test_timeout (test_timeout),
        .result_q     (result_q),
        .test_num_q   (test_num_q)
    );

    // Behavioural reference: abstract verdict, registers, cycles spent running.
    int          m_state = M_RUN;
    logic [31:0] m_result = 0, m_tnum = 0, m_rd = 0, m_run = 0;

    function automatic logic [31:0] status_word(input int st);
        case (st)
            M_PASS:    return 32'h3;
            M_FAIL:    return 32'h5;
            M_TIMEOUT: return 32'h9;
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] cycle_word(input logic [31:0] c);
`ifdef TEST_STATUS_CYCLE_CNT_EN
        return c;
`else
        return 32'd0 & c;
`endif
    endfunction

    always @(posedge clk) begin
        int nxt;
        logic [29:0] wa;
        if (reset) begin
            m_state = M_RUN; m_result = 0; m_tnum = 0; m_run = 0; m_rd = 0;
        end else begin
            wa = DataADDR[31:2];
            if (mem_read_req) begin
                if      (wa == 30'h3FFC >> 2) m_rd = m_result;
                else if (wa == 30'h3FF8 >> 2) m_rd = m_tnum;
                else if (wa == 30'h3FF0 >> 2) m_rd = status_word(m_state);
                else if (wa == 30'h3FF4 >> 2) m_rd = cycle_word(m_run);
                else                          m_rd = 0;
            end
            if (wa == 30'h3FF8 >> 2)
                for (int i = 0; i < 4; i++)
                    if (mem_write_req[i]) m_tnum[8*i +: 8] = WriteData[8*i +: 8];
            nxt = m_state;
            if (m_state == M_RUN) begin
                if (wa == 30'h3FFC >> 2 && mem_write_req == 4'hF) begin
                    m_result = WriteData;
                    if (WriteData == PASSC)      nxt = M_PASS;
                    else if (WriteData == FAILC) nxt = M_FAIL;
                end
                if (nxt == M_RUN && m_run == TO - 1) nxt = M_TIMEOUT;
                m_run = m_run + 1;
            end
            m_state = nxt;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ReadData",   ReadData,   m_rd);
            chk("result_q",   result_q,   m_result);
            chk("test_num_q", test_num_q, m_tnum);
            chk("status", {28'd0, test_timeout, test_fail, test_pass, test_done},
                status_word(m_state));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        DataADDR = a; WriteData = d; mem_write_req = s;
        @(posedge clk); #1;
        mem_write_req = 4'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        DataADDR = a; mem_read_req = 1'b1;
        @(posedge clk); #1;
        mem_read_req = 1'b0;
        d = ReadData;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] exp_cyc;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_en = 1'b1;
        chk("reset_flags", {28'd0, test_timeout, test_fail, test_pass, test_done}, 32'h0);
        chk("reset_result", result_q, 32'h0);
        chk("reset_rdata", ReadData, 32'h0);

        // Pass at cycle 5, later fail code ignored.
        do_reset(); idle(4);
        wr(32'h3FFC, PASSC, 4'hF);
        chk("pass_flags", {test_pass, test_done}, 32'h3);
        wr(32'h3FFC, FAILC, 4'hF);
        chk("pass_sticky", {28'd0, test_timeout, test_fail, test_pass, test_done}, 32'h3);
        chk("pass_result", result_q, PASSC);

        // Test number then fail via unaligned address.
        do_reset();
        wr(32'h3FF8, 32'h3, 4'hF);
        wr(32'h3FFE, FAILC, 4'hF);
        rd(32'h3FF0, v);
        chk("fail_status_rd", v, 32'h5);
        chk("fail_tnum", test_num_q, 32'h3);
        chk("fail_model", status_word(m_state), 32'h5);

        // Partial strobes.
        do_reset();
        wr(32'h3FFC, 32'h12345678, 4'b0011);
        chk("partial_result", result_q, 32'h0);
        chk("partial_done", {31'd0, test_done}, 32'h0);
        wr(32'h3FF8, 32'h00AB0000, 4'b0100);
        chk("byte_tnum", test_num_q, 32'h00AB0000);

        // Watchdog expiry and write-wins race.
        do_reset(); idle(19);
        chk("wdog_before", {31'd0, test_timeout}, 32'h0);
        idle(1);
        chk("wdog_expire", {31'd0, test_timeout}, 32'h1);
        rd(32'h3FF0, v);
        chk("timeout_status_rd", v, 32'h9);
        do_reset(); idle(19);
        wr(32'h3FFC, PASSC, 4'hF);
        chk("race_pass", {test_timeout, test_pass}, 32'h1);

        // Reset out of PASS restarts the watchdog.
        wr(32'h3FFC, PASSC, 4'hF);
        do_reset();
        chk("rst_flags", {28'd0, test_timeout, test_fail, test_pass, test_done}, 32'h0);
        chk("rst_result", result_q, 32'h0);
        idle(19);
        chk("rst_wdog_before", {31'd0, test_timeout}, 32'h0);
        idle(1);
        chk("rst_wdog_expire", {31'd0, test_timeout}, 32'h1);

        // Cycle register freezes after the verdict.
`ifdef TEST_STATUS_CYCLE_CNT_EN
        exp_cyc = 32'd10;
`else
        exp_cyc = 32'd0;
`endif
        do_reset(); idle(9);
        wr(32'h3FFC, PASSC, 4'hF);
        idle(10);
        rd(32'h3FF4, v);
        chk("cycle_rd1", v, exp_cyc);
        idle(20);
        rd(32'h3FF4, v);
        chk("cycle_rd2", v, exp_cyc);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 5))
                0: DataADDR = 32'h3FFC;
                1: DataADDR = 32'h3FF8;
                2: DataADDR = 32'h3FF0;
                3: DataADDR = 32'h3FF4;
                4: DataADDR = {30'h3FFC >> 2, 2'b00} | 32'($urandom_range(0, 3));
                default: DataADDR = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: WriteData = PASSC;
                1: WriteData = FAILC;
                default: WriteData = $urandom;
            endcase
            mem_write_req = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            if ($urandom_range(0, 2) == 0) mem_write_req = 4'h0;
            mem_read_req = 1'($urandom);
            reset = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; mem_write_req = 4'h0; mem_read_req = 1'b0;
        idle(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
